// File: rtl/spi_slave_port.sv
// ---------------------------------------------------------------------------
// spi_slave_port
//
// SPI mode-0 responder for the Murax SoC. The SPI pins are oversampled in the
// io_mainClk domain. Received bytes go to the core through a one-entry RX
// holding register. Transmitted bytes come from a one-entry TX holding
// register that the core loads.
//
// Ports
//   io_mainClk         system clock; all logic is on its rising edge
//   io_asyncReset_n    asynchronous active-low reset, released synchronously
//   io_spi_sclk        SPI clock from the master (idles low)
//   io_spi_mosi        master-out data
//   io_spi_ss_n        slave select, active low
//   io_spi_miso        slave-out data (0 while not selected)
//   io_spi_misoEnable  MISO pad enable, follows synchronized select
//   io_tx_valid/ready/payload   core -> TX holding register handshake
//   io_rx_valid/ready/payload   RX holding register -> core handshake
//   io_rxOverrun       1-cycle pulse: a completed byte was dropped
//   io_txUnderrun      1-cycle pulse: 0xFF was loaded because TX was empty
//   io_busy            synchronized select is active
// ---------------------------------------------------------------------------
module spi_slave_port #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  io_mainClk,
  input  logic                  io_asyncReset_n,
  input  logic                  io_spi_sclk,
  input  logic                  io_spi_mosi,
  input  logic                  io_spi_ss_n,
  output logic                  io_spi_miso,
  output logic                  io_spi_misoEnable,
  input  logic                  io_tx_valid,
  output logic                  io_tx_ready,
  input  logic [DATA_WIDTH-1:0] io_tx_payload,
  output logic                  io_rx_valid,
  input  logic                  io_rx_ready,
  output logic [DATA_WIDTH-1:0] io_rx_payload,
  output logic                  io_rxOverrun,
  output logic                  io_txUnderrun,
  output logic                  io_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [1:0]             rst_pipe;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] sclk_pipe, mosi_pipe, ss_pipe;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-2:0]  rx_shift;
  logic [DATA_WIDTH-1:0]  rx_word;
  logic [DATA_WIDTH-1:0]  rx_hold;
  logic                   rx_valid;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  tx_hold;
  logic                   tx_full;
  logic                   rx_overrun, tx_underrun;

  logic tx_load, tx_shift_en, rx_step, byte_done, rx_accept, tx_write, leave;

  // Reset is asserted asynchronously but released through two flops so every
  // register below leaves reset on the same clock edge.
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) rst_pipe <= '0;
    else                  rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // Pin synchronizers plus one extra register for edge detection. Select
  // resets to its idle (high) level so an idle bus produces no event.
  always_ff @(posedge io_mainClk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_pipe <= '0;
      mosi_pipe <= '0;
      ss_pipe   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], io_spi_sclk};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], io_spi_mosi};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], io_spi_ss_n};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
  assign ss_s      = ss_pipe[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  always_ff @(posedge io_mainClk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle datapath strobes. A deselect takes priority over
  // any SCLK event seen in the same cycle, so a partial byte never completes.
  always_comb begin
    state_d     = state_q;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    rx_step     = 1'b0;
    leave       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          tx_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          leave   = 1'b1;
        end else begin
          rx_step = sclk_rise;
          if (sclk_fall) begin
            tx_load     = (bit_cnt == '0);
            tx_shift_en = (bit_cnt != '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_word   = {rx_shift, mosi_s};
  assign byte_done = rx_step & (bit_cnt == LAST_BIT);
  assign rx_accept = byte_done & (~rx_valid | io_rx_ready);
  assign tx_write  = io_tx_valid & ~tx_full;

  // Bit counter and receive path. A completed byte may overwrite the holding
  // register only if it is empty or being drained in this very cycle.
  always_ff @(posedge io_mainClk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      rx_hold    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= byte_done & ~rx_accept;
      if (leave || (state_q == IDLE && tx_load)) begin
        bit_cnt <= '0;
      end else if (rx_step) begin
        bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        rx_shift <= rx_word[DATA_WIDTH-2:0];
      end
      if (rx_accept) begin
        rx_hold  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_valid && io_rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  // Transmit path. A load drains the holding register or substitutes all-ones;
  // a core write in the same cycle as an underrun load is kept for next time.
  always_ff @(posedge io_mainClk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= tx_load & ~tx_full;
      if (tx_load)          tx_shift <= tx_full ? tx_hold : '1;
      else if (tx_shift_en) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      if (tx_load && tx_full) tx_full <= 1'b0;
      else if (tx_write)      tx_full <= 1'b1;
      if (tx_write) tx_hold <= io_tx_payload;
    end
  end

  assign io_spi_miso       = (state_q == ACTIVE) & tx_shift[DATA_WIDTH-1];
  assign io_spi_misoEnable = (state_q == ACTIVE);
  assign io_busy           = (state_q == ACTIVE);
  assign io_tx_ready       = ~tx_full;
  assign io_rx_valid       = rx_valid;
  assign io_rx_payload     = rx_hold;
  assign io_rxOverrun      = rx_overrun;
  assign io_txUnderrun     = tx_underrun;

endmodule

// File: tb/tb_spi_slave_port.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_port
//
// Directed bench for spi_slave_port. Acts as a mode-0 SPI master running at
// f_main/16 (8 main cycles per SCLK half-period) and as the core on the
// TX/RX handshakes. Inputs change on the falling edge of io_mainClk and
// outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_spi_slave_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, mosi, ss_n, miso, miso_en;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0] tx_payload, rx_payload;
  logic       rx_overrun, tx_underrun, busy;

  int errors = 0;
  int checks = 0;
  int underrun_cnt = 0;
  int overrun_cnt = 0;
  int u0, o0;
  logic [7:0] mi;

  always #5 clk = ~clk;

  spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .io_mainClk        (clk),
    .io_asyncReset_n   (rst_n),
    .io_spi_sclk       (sclk),
    .io_spi_mosi       (mosi),
    .io_spi_ss_n       (ss_n),
    .io_spi_miso       (miso),
    .io_spi_misoEnable (miso_en),
    .io_tx_valid       (tx_valid),
    .io_tx_ready       (tx_ready),
    .io_tx_payload     (tx_payload),
    .io_rx_valid       (rx_valid),
    .io_rx_ready       (rx_ready),
    .io_rx_payload     (rx_payload),
    .io_rxOverrun      (rx_overrun),
    .io_txUnderrun     (tx_underrun),
    .io_busy           (busy)
  );

  // Pulse counters: one count per cycle a pulse is high, so a stretched
  // pulse shows up as a count above one.
  always @(negedge clk) begin
    if (tx_underrun === 1'b1) underrun_cnt++;
    if (rx_overrun === 1'b1)  overrun_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    tx_valid   = 1'b1;
    tx_payload = d;
    wait_cycles(1);
    tx_valid   = 1'b0;
  endtask

  task automatic rx_consume();
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
  endtask

  task automatic select();
    ss_n = 1'b0;
    wait_cycles(8);
  endtask

  task automatic deselect();
    ss_n = 1'b1;
    wait_cycles(8);
  endtask

  // Sends the top nbits of mo MSB first and collects MISO just before each
  // rising edge. With pulse_ready set, rx_ready is high for exactly the cycle
  // in which the last rising edge is processed (third clock after the pin).
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit pulse_ready,
                          output logic [7:0] mi_out);
    mi_out = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_cycles(8);
      mi_out[7-i] = miso;
      sclk = 1'b1;
      if (pulse_ready && i == nbits - 1) begin
        wait_cycles(2);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        wait_cycles(5);
      end else begin
        wait_cycles(8);
      end
      sclk = 1'b0;
    end
    wait_cycles(8);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    tx_valid = 1'b0; tx_payload = '0; rx_ready = 1'b0;
    wait_cycles(3);

    // Reset values
    check_output("rst_tx_ready", tx_ready, 1);
    check_output("rst_rx_valid", rx_valid, 0);
    check_output("rst_rx_payload", rx_payload, 0);
    check_output("rst_miso", miso, 0);
    check_output("rst_miso_en", miso_en, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_pulses", {rx_overrun, tx_underrun}, 0);
    rst_n = 1'b1;
    wait_cycles(4);

    // Single byte: TX 0xA5 preloaded, master sends 0x3C
    tx_write(8'hA5);
    check_output("t1_tx_full", tx_ready, 0);
    u0 = underrun_cnt; o0 = overrun_cnt;
    select();
    check_output("t1_busy", busy, 1);
    check_output("t1_miso_en", miso_en, 1);
    check_output("t1_tx_drained", tx_ready, 1);
    check_output("t1_no_underrun", underrun_cnt - u0, 0);
    spi_xfer(8'h3C, 8, 1'b0, mi);
    check_output("t1_miso_byte", mi, 8'hA5);
    check_output("t1_rx_valid", rx_valid, 1);
    check_output("t1_rx_payload", rx_payload, 8'h3C);
    check_output("t1_no_overrun", overrun_cnt - o0, 0);
    deselect();
    check_output("t1_idle_busy", busy, 0);
    check_output("t1_idle_miso", miso, 0);
    rx_consume();
    check_output("t1_rx_cleared", rx_valid, 0);

    // Two bytes: 0x12 preloaded, 0x34 written once tx_ready returns
    tx_write(8'h12);
    select();
    check_output("t2_tx_ready", tx_ready, 1);
    tx_write(8'h34);
    spi_xfer(8'h81, 8, 1'b0, mi);
    check_output("t2_miso_b0", mi, 8'h12);
    check_output("t2_rx_b0", rx_payload, 8'h81);
    check_output("t2_tx_reload", tx_ready, 1);
    rx_consume();
    spi_xfer(8'h7E, 8, 1'b0, mi);
    check_output("t2_miso_b1", mi, 8'h34);
    check_output("t2_rx_b1", {7'd0, rx_valid, rx_payload}, {7'd0, 1'b1, 8'h7E});
    deselect();
    rx_consume();

    // TX empty at select: 0xFF and one single-cycle underrun pulse
    u0 = underrun_cnt;
    select();
    check_output("t3_underrun_pulse", underrun_cnt - u0, 1);
    spi_xfer(8'h55, 8, 1'b0, mi);
    check_output("t3_miso_ff", mi, 8'hFF);
    check_output("t3_rx_payload", rx_payload, 8'h55);
    deselect();
    rx_consume();

    // Overrun: rx_ready held low across two bytes
    o0 = overrun_cnt;
    select();
    spi_xfer(8'h11, 8, 1'b0, mi);
    check_output("t4_rx_first", rx_payload, 8'h11);
    spi_xfer(8'h22, 8, 1'b0, mi);
    check_output("t4_overrun_pulse", overrun_cnt - o0, 1);
    check_output("t4_rx_kept", rx_payload, 8'h11);
    deselect();
    rx_consume();
    check_output("t4_rx_cleared", rx_valid, 0);

    // Same-cycle drain at completion of the second byte: no overrun
    o0 = overrun_cnt;
    select();
    spi_xfer(8'h11, 8, 1'b0, mi);
    spi_xfer(8'h22, 8, 1'b1, mi);
    check_output("t4b_rx_new", rx_payload, 8'h22);
    check_output("t4b_rx_valid", rx_valid, 1);
    check_output("t4b_no_overrun", overrun_cnt - o0, 0);
    deselect();
    rx_consume();

    // Partial byte then deselect, then a clean 0xC3 transfer
    select();
    spi_xfer(8'hA0, 5, 1'b0, mi);
    ss_n = 1'b1;
    wait_cycles(2);
    check_output("t5_miso_en_held", miso_en, 1);
    wait_cycles(1);
    check_output("t5_miso_en_fall", miso_en, 0);
    wait_cycles(5);
    check_output("t5_no_partial_rx", rx_valid, 0);
    select();
    spi_xfer(8'hC3, 8, 1'b0, mi);
    check_output("t5_rx_aligned", {7'd0, rx_valid, rx_payload}, {7'd0, 1'b1, 8'hC3});
    deselect();
    rx_consume();

    // Asynchronous reset in the middle of a byte, between clock edges
    tx_write(8'h5A);
    select();
    tx_write(8'h66);
    check_output("t6_tx_full", tx_ready, 0);
    spi_xfer(8'hF0, 3, 1'b0, mi);
    sclk = 1'b1;
    wait_cycles(3);
    #2 rst_n = 1'b0;
    #1;
    check_output("t6_async_tx_ready", tx_ready, 1);
    check_output("t6_async_outputs", {miso_en, busy, miso, rx_valid}, 0);
    sclk = 1'b0;
    ss_n = 1'b1;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(4);
    tx_write(8'h96);
    select();
    spi_xfer(8'h69, 8, 1'b0, mi);
    check_output("t6_post_miso", mi, 8'h96);
    check_output("t6_post_rx", {7'd0, rx_valid, rx_payload}, {7'd0, 1'b1, 8'h69});
    deselect();
    rx_consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
SPI mode-0 slave for the Murax SoC, used where the ice40 must respond to an external SPI master such as the STM32 co-processor or a second board's SPI master. All pins are oversampled in the io_mainClk domain. Each full byte received on MOSI is handed to the core through a one-entry RX holding register. Each byte shifted out on MISO comes from a one-entry TX holding register loaded by the core. The block is the responder end of the SPI master interface already on the SoC.

Parameters:
DATA_WIDTH, 8, bits per SPI transfer unit; MSB first.
SYNC_STAGES, 2, synchronizer flops on sclk, mosi and ss_n; legal range is at least 2.

Ports:
io_mainClk  in  1  system clock; all logic is on its rising edge.
io_asyncReset_n  in  1  asynchronous, active-low reset.
io_spi_sclk  in  1  SPI clock from the master; idles low.
io_spi_mosi  in  1  master-out data.
io_spi_ss_n  in  1  slave select, active low.
io_spi_miso  out  1  slave-out data.
io_spi_misoEnable  out  1  MISO pad output enable; equals synchronized select.
io_tx_valid  in  1  core offers a TX byte.
io_tx_ready  out  1  TX holding register is empty.
io_tx_payload  in  DATA_WIDTH  TX byte.
io_rx_valid  out  1  RX holding register is full.
io_rx_ready  in  1  core consumes the RX byte.
io_rx_payload  out  DATA_WIDTH  RX byte.
io_rxOverrun  out  1  one-cycle pulse: a received byte was dropped.
io_txUnderrun  out  1  one-cycle pulse: 0xFF was sent because TX was empty.
io_busy  out  1  select is active (synchronized).

Behaviour:
- Reset (async assert, sync release): all outputs are 0 except io_tx_ready=1. Shift registers are 0, bitCnt=0, holding registers are empty.
- Input synchronization: sclk, mosi and ss_n each pass through SYNC_STAGES flops. One further register provides edge detection. A pin edge becomes an internal event SYNC_STAGES+1 cycles later.
- Timing requirement: each SCLK half-period must be at least SYNC_STAGES+2 io_mainClk cycles, i.e. f_sclk ≤ f_main/8 at the default. Operation outside this is undefined; the bench must not exercise it.
- FSM states: IDLE (ss_n high) and ACTIVE.
  - IDLE→ACTIVE on a synchronized ss_n falling edge: bitCnt=0, io_spi_misoEnable=1, and the TX shift register is loaded (see TX load). MISO presents the MSB in the same cycle as the load.
  - ACTIVE→IDLE on a synchronized ss_n rising edge: misoEnable=0, miso=0, bitCnt=0. Any partial RX byte is discarded with no rx_valid and no overrun. A TX byte already loaded counts as consumed.
- SCLK rising event while ACTIVE:
  - rxShift <= {rxShift[W-2:0], mosi_sync}; bitCnt wraps mod DATA_WIDTH.
  - When bitCnt was DATA_WIDTH-1, the byte is complete. If the RX holding register is empty, or is being consumed this same cycle (rx_valid & rx_ready), write the byte and set rx_valid next cycle. Otherwise drop the new byte, keep the old byte, and pulse io_rxOverrun.
- SCLK falling event while ACTIVE:
  - If bitCnt==0, this is a byte boundary: perform a TX load.
  - Otherwise shift txShift left by one; miso = txShift MSB.
  - In mode 0 no falling edge occurs before the first rising edge, so bitCnt==0 on a falling edge always means a boundary.
- TX load:
  - If the TX holding register is full, move it to txShift and set tx_ready=1 next cycle.
  - Otherwise load all-ones into txShift and pulse io_txUnderrun.
  - If io_tx_valid&io_tx_ready occurs in the same cycle as a load from an empty holding register, the 0xFF/underrun is still sent. The offered byte is captured into the holding register for the next load.
- TX handshake: the core writes when tx_valid&tx_ready; tx_ready then drops the following cycle. tx_payload is sampled only on that cycle.
- RX handshake: rx_payload is stable while rx_valid=1. rx_valid clears the cycle after rx_valid&rx_ready.
- MOSI is sampled only on synchronized rising events, and the SYNC_STAGES skew is identical for sclk and mosi.
- Events that arrive while IDLE are ignored.

Test Plan:
- Pre-load TX=0xA5, select, master sends 0x3C (8 clocks, f_main/16), deselect → master reads 0xA5; rx_valid=1 with payload 0x3C; no underrun or overrun.
- Two-byte transfer with TX=0x12 loaded, then 0x34 written after tx_ready rises, master sends 0x81,0x7E with core consuming promptly → MISO shows 0x12,0x34; RX bytes are 0x81 then 0x7E.
- Select with TX empty, one byte → MISO=0xFF; io_txUnderrun is a single-cycle pulse at the select load.
- Master sends 0x11,0x22 with rx_ready held low → payload stays 0x11; io_rxOverrun pulses once after the 16th rising edge. Asserting rx_ready in the exact completion cycle of the second byte instead → 0x22 accepted, no overrun.
- Deselect after 5 clocks, then a new full transfer of 0xC3 → no rx_valid from the partial byte; next RX=0xC3 correctly aligned; misoEnable falls with synchronized ss_n.
- Assert io_asyncReset_n low mid-byte without a clock edge → outputs clear immediately (tx_ready=1); after release the next full transfer works normally.
